// File: rtl/up_uart_pkg.sv
// up_uart_pkg: shared definitions for the up UART receive peripheral.
// Holds the receiver FSM encoding, STATUS register bit positions, register
// select codes and the even-parity helper used when UP_UART_RX_PARITY_EN is set.
package up_uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } rx_state_e;

  // STATUS register bit positions
  localparam int STAT_NEMPTY = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_OVR    = 2;
  localparam int STAT_FERR   = 3;
  localparam int STAT_PERR   = 4;

  // Register select on the read bus
  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  // Even parity: data bits plus parity bit must hold an even number of ones.
  function automatic logic even_parity_ok(input logic [7:0] dat, input logic par);
    return ~(^{dat, par});
  endfunction

endpackage

// File: rtl/up_uart_rx_fifo.sv
// up_uart_rx_fifo: synchronous DEPTH x 8 FIFO for received bytes.
// Ports: clk/nRst; push_i/din_i write, pop_i read (dout_o shows the head
// combinationally); full_o, empty_o and count_o report occupancy.
// A push while full is accepted only if a pop happens in the same cycle;
// a pop while empty is ignored.
module up_uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the head slot this cycle, so a push into a full FIFO still fits.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/up_uart_rx.sv
// up_uart_rx: memory-mapped UART receiver (8N1, or 8E1 with UP_UART_RX_PARITY_EN).
// Ports: clk, nRst (async active-low); rx serial in (async, idle high);
// re/addr read strobe and select (0 DATA, 1 STATUS); out registered read data
// (one cycle after re, held until next re); irq high while the FIFO is non-empty.
module up_uart_rx
  import up_uart_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int DEPTH   = 4
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx,
  input  logic       re,
  input  logic       addr,
  output logic [7:0] out,
  output logic       irq
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV/2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLK_DIV - 1);

  // Two-flop synchroniser; only rx_sync_q is used downstream.
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver FSM
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_bit_q, par_bit_d;
  logic          par_bad;
  logic          expired;
  logic          push_req;
  logic          ferr_set;
  logic          perr_set;

  assign expired = (cnt_q == '0);

`ifdef UP_UART_RX_PARITY_EN
  assign par_bad = ~even_parity_ok(shift_q, par_bit_q);
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    perr_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (expired) begin
          // Line back high at mid start bit: a glitch, not a frame.
          if (rx_sync_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
            cnt_d     = CNT_FULL;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (expired) begin
          shift_d[bit_idx_q] = rx_sync_q;
          cnt_d              = CNT_FULL;
          if (bit_idx_q == 3'd7) begin
`ifdef UP_UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PARITY: begin
`ifdef UP_UART_RX_PARITY_EN
        if (expired) begin
          par_bit_d = rx_sync_q;
          cnt_d     = CNT_FULL;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (expired) begin
          perr_set = par_bad;
          if (rx_sync_q) begin
            push_req = ~par_bad;
            state_d  = IDLE;
          end else begin
            // Low stop bit: framing error; wait out any break before re-arming.
            ferr_set = 1'b1;
            state_d  = WAIT_HI;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT_HI: begin
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
    end
  end

  // Receive FIFO
  logic          rd_data, rd_stat;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;

  assign rd_data = re & (addr == ADDR_DATA);
  assign rd_stat = re & (addr == ADDR_STATUS);

  up_uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nRst    (nRst),
    .push_i  (push_req),
    .pop_i   (rd_data),
    .din_i   (shift_q),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Register read side and sticky flags
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;
  logic       perr_q, perr_d;
  logic       ovr_set;
  logic [7:0] out_q, out_d;
  logic       irq_q;
  logic [7:0] status_vec;

  // A full FIFO is never empty, so a DATA read in the same cycle frees room.
  assign ovr_set = push_req & fifo_full & ~rd_data;

  always_comb begin
    status_vec              = 8'h00;
    status_vec[STAT_NEMPTY] = ~fifo_empty;
    status_vec[STAT_FULL]   = fifo_full;
    status_vec[STAT_OVR]    = ovr_q;
    status_vec[STAT_FERR]   = ferr_q;
    status_vec[STAT_PERR]   = perr_q;
  end

  always_comb begin
    out_d = out_q;
    if (rd_data) out_d = fifo_empty ? 8'h00 : fifo_dout;
    if (rd_stat) out_d = status_vec;
    // Clear-on-read, but an event in the read cycle keeps its flag set.
    ovr_d  = (ovr_q  & ~rd_stat) | ovr_set;
    ferr_d = (ferr_q & ~rd_stat) | ferr_set;
    perr_d = (perr_q & ~rd_stat) | perr_set;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      out_q  <= 8'h00;
      irq_q  <= 1'b0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      irq_q  <= (fifo_count != '0);
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
      perr_q <= perr_d;
    end
  end

  assign out = out_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_up_uart_rx.sv
module tb_up_uart_rx;
  import up_uart_pkg::*;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;

  logic       clk  = 1'b0;
  logic       nRst = 1'b0;
  logic       rx   = 1'b1;
  logic       re   = 1'b0;
  logic       addr = 1'b0;
  logic [7:0] out;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;

  up_uart_rx #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .nRst (nRst),
    .rx   (rx),
    .re   (re),
    .addr (addr),
    .out  (out),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: byte queue plus sticky flags.
  logic [7:0] mq[$];
  bit m_ovr, m_ferr, m_perr;

  function automatic logic [7:0] model_status();
    logic [7:0] s;
    s = 8'h00;
    s[0] = (mq.size() != 0);
    s[1] = (mq.size() == DEPTH);
    s[2] = m_ovr;
    s[3] = m_ferr;
    s[4] = m_perr;
    return s;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic a, output logic [7:0] d);
    @(negedge clk);
    re   = 1'b1;
    addr = a;
    @(negedge clk);
    re = 1'b0;
    d  = out;
  endtask

  task automatic rd_check(input string name, input logic a, input logic [7:0] exp);
    logic [7:0] d;
    rd(a, d);
    check8(name, d, exp);
  endtask

  task automatic irq_check(input string name, input logic exp);
    idle(2);
    check8(name, {7'd0, irq}, {7'd0, exp});
  endtask

  // Model-driven reads
  task automatic m_status(input string name);
    logic [7:0] d, e;
    e = model_status();
    m_ovr = 0; m_ferr = 0; m_perr = 0;
    rd(ADDR_STATUS, d);
    check8(name, d, e);
  endtask

  task automatic m_data(input string name);
    logic [7:0] d, e;
    e = (mq.size() != 0) ? mq.pop_front() : 8'h00;
    rd(ADDR_DATA, d);
    check8(name, d, e);
  endtask

  // Drive one frame. Optionally issues a DATA read in the cycle the stop bit
  // is sampled and returns what that read produced.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                            input int low_hold, input bit rd_at_stop,
                            output logic [7:0] rd_val);
    logic bits [11];
    int nb;
    rd_val = 8'h00;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 9;
`ifdef UP_UART_RX_PARITY_EN
    bits[nb] = (^d) ^ !par_ok;
    nb++;
`endif
    bits[nb] = stop_ok;
    nb++;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      rx = bits[i];
      for (int j = 1; j < CLK_DIV; j++) begin
        @(negedge clk);
        if (rd_at_stop && i == nb-1 && j == CLK_DIV/2 + 2) begin
          re   = 1'b1;
          addr = ADDR_DATA;
        end else if (rd_at_stop && i == nb-1 && j == CLK_DIV/2 + 3) begin
          re     = 1'b0;
          rd_val = out;
        end
      end
    end
    if (!stop_ok) idle(low_hold);
    @(negedge clk);
    rx = 1'b1;
    idle(2*CLK_DIV);
  endtask

  typedef struct {
    logic [7:0] dat;
    bit         stop_ok;
    int         low_hold;
    logic [7:0] exp_stat;
    logic [7:0] exp_dat;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [7:0] tmp;
    logic [7:0] rnd;
    bit s_ok, p_ok;
    int hold, nr;

    tbl[0] = '{8'hA5, 1'b1, 0,  8'h01, 8'hA5};
    tbl[1] = '{8'h3C, 1'b0, 40, 8'h08, 8'h00};
    tbl[2] = '{8'h11, 1'b1, 0,  8'h01, 8'h11};
    tbl[3] = '{8'h00, 1'b1, 0,  8'h01, 8'h00};
    tbl[4] = '{8'hFF, 1'b1, 0,  8'h01, 8'hFF};
    tbl[5] = '{8'h80, 1'b0, 5,  8'h08, 8'h00};

    // Reset state
    idle(3);
    check8("reset_out", out, 8'h00);
    check8("reset_irq", {7'd0, irq}, 8'h00);
    nRst = 1'b1;
    idle(4);
    rd_check("reset_status", ADDR_STATUS, 8'h00);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].dat, tbl[i].stop_ok, 1'b1, tbl[i].low_hold, 1'b0, tmp);
      irq_check($sformatf("tbl%0d_irq", i), tbl[i].exp_stat[0]);
      rd_check($sformatf("tbl%0d_status", i), ADDR_STATUS, tbl[i].exp_stat);
      rd_check($sformatf("tbl%0d_data", i), ADDR_DATA, tbl[i].exp_dat);
      rd_check($sformatf("tbl%0d_status2", i), ADDR_STATUS, 8'h00);
      irq_check($sformatf("tbl%0d_irq2", i), 1'b0);
    end

    // Short low glitch must not start a frame
    @(negedge clk);
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3*CLK_DIV);
    rd_check("glitch_status", ADDR_STATUS, 8'h00);
    irq_check("glitch_irq", 1'b0);

    // Fill past DEPTH without reading
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1, 0, 1'b0, tmp);
    rd_check("fill_status", ADDR_STATUS, 8'h07);
    for (int i = 1; i <= 4; i++) rd_check($sformatf("fill_data%0d", i), ADDR_DATA, 8'(i));
    rd_check("fill_data_empty", ADDR_DATA, 8'h00);
    rd_check("fill_status2", ADDR_STATUS, 8'h00);

    // DATA read in the same cycle as a push
    send_frame(8'h77, 1'b1, 1'b1, 0, 1'b0, tmp);
    send_frame(8'h99, 1'b1, 1'b1, 0, 1'b1, tmp);
    check8("same_cycle_old", tmp, 8'h77);
    irq_check("same_cycle_irq", 1'b1);
    rd_check("same_cycle_status", ADDR_STATUS, 8'h01);
    rd_check("same_cycle_new", ADDR_DATA, 8'h99);
    rd_check("same_cycle_empty", ADDR_DATA, 8'h00);

    // Reset in the middle of a frame of 0xFF
    @(negedge clk);
    rx = 1'b0;
    idle(CLK_DIV);
    rx = 1'b1;
    idle(3*CLK_DIV + CLK_DIV/2);
    nRst = 1'b0;
    idle(3);
    check8("midreset_out", out, 8'h00);
    nRst = 1'b1;
    idle(2*CLK_DIV);
    rd_check("midreset_status", ADDR_STATUS, 8'h00);
    send_frame(8'h5A, 1'b1, 1'b1, 0, 1'b0, tmp);
    rd_check("after_reset_status", ADDR_STATUS, 8'h01);
    rd_check("after_reset_data", ADDR_DATA, 8'h5A);
    rd_check("after_reset_empty", ADDR_DATA, 8'h00);
`ifdef UP_UART_RX_PARITY_EN
    send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b0, tmp);
    rd_check("parity_status", ADDR_STATUS, 8'h10);
    rd_check("parity_data", ADDR_DATA, 8'h00);
    rd_check("parity_status2", ADDR_STATUS, 8'h00);
`endif

    // Randomized frames against the behavioural model
    mq.delete();
    m_ovr = 0; m_ferr = 0; m_perr = 0;
    for (int it = 0; it < 24; it++) begin
      rnd  = 8'($urandom);
      s_ok = ($urandom_range(0, 4) != 0);
`ifdef UP_UART_RX_PARITY_EN
      p_ok = ($urandom_range(0, 5) != 0);
`else
      p_ok = 1'b1;
`endif
      hold = $urandom_range(0, 30);
      send_frame(rnd, s_ok, p_ok, hold, 1'b0, tmp);
      if (!p_ok) m_perr = 1;
      if (!s_ok) m_ferr = 1;
      else if (p_ok) begin
        if (mq.size() == DEPTH) m_ovr = 1;
        else mq.push_back(rnd);
      end
      nr = $urandom_range(0, 3);
      for (int k = 0; k < nr; k++) begin
        if ($urandom_range(0, 2) == 0) m_status($sformatf("rnd%0d_status", it));
        else m_data($sformatf("rnd%0d_data", it));
      end
      irq_check($sformatf("rnd%0d_irq", it), mq.size() != 0);
    end
    m_status("drain_status");
    for (int k = 0; k <= DEPTH; k++) m_data("drain_data");
    m_status("drain_status2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
